bip_control: RTL and testbench

- Control unit for the BIP accumulator processor. It fetches 16-bit instructions from program memory, decodes the opcode and operand, and sequences the datapath controls and the data-RAM read/write strobes.
- It is the counterpart of the accumulator datapath: it drives that block's selA/selB/wrAcc/op/operando inputs and the RAM port whose read data feeds the datapath.

---
 rtl/bip_control.sv | 152 +++++++++++++++
 tb/tb_bip_control.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// BIP accumulator-processor control unit: fetches instructions, decodes them and
// sequences datapath controls plus program/data RAM strobes.
module bip_control #(
    parameter int NB_PC            = 11,
    parameter int NB_INSTR         = 16,
    parameter int NB_OPCODE        = 5,
    parameter int NB_OPERANDO      = 11,
    parameter int NB_DECODER_SEL_A = 2,
    parameter int NB_CYCLES        = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_enable,
    input  logic [NB_INSTR-1:0]         i_instr,
    output logic [NB_PC-1:0]            o_pc,
    output logic                        o_rd_prog,
    output logic [NB_DECODER_SEL_A-1:0] o_selA,
    output logic                        o_selB,
    output logic                        o_wrAcc,
    output logic [NB_OPCODE-1:0]        o_op,
    output logic [NB_OPERANDO-1:0]      o_operando,
    output logic [NB_OPERANDO-1:0]      o_ram_addr,
    output logic                        o_rd_ram,
    output logic                        o_wr_ram,
    output logic                        o_halt,
    output logic [NB_CYCLES-1:0]        o_cycle_count
);

    // state  | meaning
    // IDLE   | after reset, waiting for i_enable
    // FETCH  | program memory read of pc
    // DECODE | instruction word arrives, latched into ir
    // MEM    | data RAM read for LD/ADD/SUB
    // EXEC   | datapath controls driven, pc advances
    // HALT   | stopped until reset
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

    localparam logic [NB_DECODER_SEL_A-1:0] SEL_RAM = NB_DECODER_SEL_A'(0);
    localparam logic [NB_DECODER_SEL_A-1:0] SEL_IMM = NB_DECODER_SEL_A'(1);
    localparam logic [NB_DECODER_SEL_A-1:0] SEL_ALU = NB_DECODER_SEL_A'(2);

    localparam logic [NB_PC-1:0]     PC_ONE  = NB_PC'(1);
    localparam logic [NB_CYCLES-1:0] CNT_ONE = NB_CYCLES'(1);

    state_t                state_q, state_d;
    logic [NB_PC-1:0]      pc_q, pc_d;
    logic [NB_INSTR-1:0]   ir_q, ir_d;
    logic [NB_CYCLES-1:0]  count_q, count_d;

    logic [NB_OPCODE-1:0]  opcode_q;
    logic [NB_OPCODE-1:0]  opcode_in;

    assign opcode_q  = ir_q[NB_INSTR-1 -: NB_OPCODE];
    assign opcode_in = i_instr[NB_INSTR-1 -: NB_OPCODE];

    function automatic logic is_mem_op(input logic [NB_OPCODE-1:0] op);
        return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        count_d = count_q;
        if (i_enable) begin
            case (state_q)
                ST_IDLE:   state_d = ST_FETCH;
                ST_FETCH:  state_d = ST_DECODE;
                ST_DECODE: begin
                    ir_d    = i_instr;
                    state_d = is_mem_op(opcode_in) ? ST_MEM : ST_EXEC;
                end
                ST_MEM:    state_d = ST_EXEC;
                ST_EXEC: begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = (opcode_q == OP_HLT) ? ST_HALT : ST_FETCH;
                end
                default:   state_d = state_q;
            endcase
            if ((state_q != ST_IDLE) && (state_q != ST_HALT) && (count_q != '1))
                count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    // Strobes are gated by i_enable so a pause silences them without touching state.
    always_comb begin
        o_selA   = SEL_RAM;
        o_selB   = 1'b0;
        o_wrAcc  = 1'b0;
        o_wr_ram = 1'b0;
        if (state_q == ST_EXEC) begin
            case (opcode_q)
                OP_STO: o_wr_ram = i_enable;
                OP_LD:  o_wrAcc  = i_enable;
                OP_LDI: begin
                    o_selA  = SEL_IMM;
                    o_wrAcc = i_enable;
                end
                OP_ADD, OP_SUB: begin
                    o_selA  = SEL_ALU;
                    o_wrAcc = i_enable;
                end
                OP_ADDI, OP_SUBI: begin
                    o_selA  = SEL_ALU;
                    o_selB  = 1'b1;
                    o_wrAcc = i_enable;
                end
                default: o_wrAcc = 1'b0;
            endcase
        end
    end

    assign o_pc          = pc_q;
    assign o_rd_prog     = i_enable && (state_q == ST_FETCH);
    assign o_rd_ram      = i_enable && (state_q == ST_MEM);
    assign o_halt        = (state_q == ST_HALT);
    assign o_op          = opcode_q;
    assign o_operando    = ir_q[NB_OPERANDO-1:0];
    assign o_ram_addr    = ir_q[NB_OPERANDO-1:0];
    assign o_cycle_count = count_q;

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: directed scenarios plus random programs
// with random pauses checked against an instruction-phase trace model.
module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] i_instr = 16'h0000;
    logic [10:0] o_pc;
    logic        o_rd_prog;
    logic [1:0]  o_selA;
    logic        o_selB;
    logic        o_wrAcc;
    logic [4:0]  o_op;
    logic [10:0] o_operando;
    logic [10:0] o_ram_addr;
    logic        o_rd_ram;
    logic        o_wr_ram;
    logic        o_halt;
    logic [31:0] o_cycle_count;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [4:0] HLT = 5'd0, STO = 5'd1, LD = 5'd2, LDI = 5'd3;
    localparam logic [4:0] ADD = 5'd4, ADDI = 5'd5, SUB = 5'd6, SUBI = 5'd7;
    localparam int K_IDLE = 0, K_FETCH = 1, K_DEC = 2, K_MEM = 3, K_EXEC = 4, K_HALT = 5;

    typedef struct {
        int          kind;
        logic [10:0] pc;
        logic [15:0] ir;
    } ph_t;

    logic [15:0] prog [0:2047];

    bip_control dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_instr(i_instr),
        .o_pc(o_pc), .o_rd_prog(o_rd_prog), .o_selA(o_selA), .o_selB(o_selB),
        .o_wrAcc(o_wrAcc), .o_op(o_op), .o_operando(o_operando),
        .o_ram_addr(o_ram_addr), .o_rd_ram(o_rd_ram), .o_wr_ram(o_wr_ram),
        .o_halt(o_halt), .o_cycle_count(o_cycle_count)
    );

    always #5 clk = ~clk;

    // Program memory: registered read, data valid the cycle after the strobe
    always @(posedge clk) if (o_rd_prog) i_instr <= prog[o_pc];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) prog[i] = 16'hF800;
    endtask

    // Reset, then release with enable high; returns at the sample point of cycle 0 (IDLE)
    task automatic start_run();
        rst = 1'b1; en = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0; en = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        @(posedge clk); #3;
        n_total++; if (o_pc !== 11'd0) $display("FAIL reset_pc: got %0h want 0", o_pc); else n_pass++;
        n_total++;
        if ({o_rd_prog, o_rd_ram, o_wr_ram, o_wrAcc, o_halt} !== 5'b0)
            $display("FAIL reset_strobes: got %b want 00000", {o_rd_prog, o_rd_ram, o_wr_ram, o_wrAcc, o_halt});
        else n_pass++;
        n_total++;
        if ({o_selA, o_selB, o_op, o_operando} !== 19'd0)
            $display("FAIL reset_sel_ir: got %0h want 0", {o_selA, o_selB, o_op, o_operando});
        else n_pass++;
        n_total++; if (o_cycle_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", o_cycle_count); else n_pass++;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        n_total++;
        if ({o_rd_prog, o_cycle_count} !== 33'd0)
            $display("FAIL idle_hold: got %0h want 0", {o_rd_prog, o_cycle_count});
        else n_pass++;
    endtask

    task automatic test_basic_program();
        int          acc_cyc[$];
        logic [2:0]  acc_sel[$];
        int          wr_cyc = -1;
        logic [10:0] wr_addr = '0;
        int          halt_cyc = -1;
        clear_prog();
        prog[0] = {LDI, 11'd5}; prog[1] = {ADDI, 11'd3}; prog[2] = {STO, 11'd7}; prog[3] = {HLT, 11'd0};
        start_run();
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #3;
            if (o_wrAcc) begin acc_cyc.push_back(c); acc_sel.push_back({o_selA, o_selB}); end
            if (o_wr_ram) begin wr_cyc = c; wr_addr = o_ram_addr; end
            if (o_halt && halt_cyc < 0) halt_cyc = c;
        end
        n_total++;
        if (acc_cyc.size() != 2 || acc_cyc[0] != 3 || acc_cyc[1] != 6)
            $display("FAIL basic_wracc_cycles: got %p want 3,6", acc_cyc);
        else n_pass++;
        n_total++;
        if (acc_sel.size() != 2 || acc_sel[0] !== 3'b010 || acc_sel[1] !== 3'b101)
            $display("FAIL basic_sel: got %p want 010,101", acc_sel);
        else n_pass++;
        n_total++;
        if (wr_cyc != 9 || wr_addr !== 11'd7)
            $display("FAIL basic_sto: got cycle %0d addr %0d want cycle 9 addr 7", wr_cyc, wr_addr);
        else n_pass++;
        n_total++; if (halt_cyc != 13) $display("FAIL basic_halt_cycle: got %0d want 13", halt_cyc); else n_pass++;
        n_total++; if (o_cycle_count !== 32'd12) $display("FAIL basic_count: got %0d want 12", o_cycle_count); else n_pass++;
        n_total++; if (o_pc !== 11'd4) $display("FAIL basic_pc: got %0d want 4", o_pc); else n_pass++;
    endtask

    task automatic test_mem_ops();
        logic [10:0] ea [3] = '{11'd2, 11'd3, 11'd4};
        logic [4:0]  eo [3] = '{LD, ADD, SUB};
        logic [1:0]  es [3] = '{2'b00, 2'b10, 2'b10};
        logic        prev_rd = 1'b0;
        logic [10:0] prev_addr = '0;
        int          k = 0;
        clear_prog();
        prog[0] = {LD, 11'd2}; prog[1] = {ADD, 11'd3}; prog[2] = {SUB, 11'd4}; prog[3] = {HLT, 11'd0};
        start_run();
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #3;
            if (o_wrAcc && k < 3) begin
                n_total++;
                if ({prev_rd, prev_addr, o_selA, o_selB, o_op} !== {1'b1, ea[k], es[k], 1'b0, eo[k]})
                    $display("FAIL mem_op%0d: got rd %b addr %0d selA %b selB %b op %b want rd 1 addr %0d selA %b selB 0 op %b",
                             k, prev_rd, prev_addr, o_selA, o_selB, o_op, ea[k], es[k], eo[k]);
                else n_pass++;
                k++;
            end
            prev_rd = o_rd_ram; prev_addr = o_ram_addr;
        end
        n_total++; if (k != 3) $display("FAIL mem_op_count: got %0d want 3", k); else n_pass++;
    endtask

    task automatic test_subi();
        int n = 0;
        clear_prog();
        prog[0] = {SUBI, 11'h7FF}; prog[1] = {HLT, 11'd0};
        start_run();
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #3;
            if (o_wrAcc) begin
                n++;
                n_total++;
                if ({o_selA, o_selB, o_operando, o_op} !== {2'b10, 1'b1, 11'h7FF, SUBI})
                    $display("FAIL subi_ctrl: got selA %b selB %b operando %h op %b want 10 1 7ff 00111",
                             o_selA, o_selB, o_operando, o_op);
                else n_pass++;
            end
        end
        n_total++; if (n != 1) $display("FAIL subi_wracc_len: got %0d want 1", n); else n_pass++;
    endtask

    task automatic test_pause_mem();
        clear_prog();
        prog[0] = {LD, 11'd5}; prog[1] = {HLT, 11'd0};
        start_run();
        @(posedge clk); #3;
        @(posedge clk); #3;
        for (int c = 3; c <= 5; c++) begin
            @(posedge clk); #1 en = 1'b0; #2;
            n_total++;
            if ({o_rd_ram, o_wrAcc, o_rd_prog, o_pc, o_cycle_count} !== {3'b000, 11'd0, 32'd2})
                $display("FAIL pause_hold_c%0d: got rd %b acc %b prog %b pc %0d cnt %0d want 0 0 0 0 2",
                         c, o_rd_ram, o_wrAcc, o_rd_prog, o_pc, o_cycle_count);
            else n_pass++;
        end
        @(posedge clk); #1 en = 1'b1; #2;
        n_total++;
        if ({o_rd_ram, o_ram_addr, o_wrAcc, o_cycle_count} !== {1'b1, 11'd5, 1'b0, 32'd2})
            $display("FAIL pause_resume_mem: got rd %b addr %0d acc %b cnt %0d want 1 5 0 2",
                     o_rd_ram, o_ram_addr, o_wrAcc, o_cycle_count);
        else n_pass++;
        @(posedge clk); #3;
        n_total++;
        if ({o_rd_ram, o_wrAcc, o_selA, o_cycle_count} !== {1'b0, 1'b1, 2'b00, 32'd3})
            $display("FAIL pause_exec: got rd %b acc %b selA %b cnt %0d want 0 1 00 3",
                     o_rd_ram, o_wrAcc, o_selA, o_cycle_count);
        else n_pass++;
    endtask

    task automatic test_pc_wrap();
        int          bad = 0, nfetch = 0;
        logic [10:0] pc_last = '0;
        for (int i = 0; i < 2048; i++) prog[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
        start_run();
        for (int c = 1; c <= 6144; c++) begin
            @(posedge clk); #3;
            if (o_rd_ram || o_wr_ram || o_wrAcc || o_halt) bad++;
            if (o_rd_prog) nfetch++;
            if (c == 6142) pc_last = o_pc;
        end
        n_total++; if (bad != 0) $display("FAIL wrap_strobes: got %0d bad cycles want 0", bad); else n_pass++;
        n_total++; if (nfetch != 2048) $display("FAIL wrap_fetches: got %0d want 2048", nfetch); else n_pass++;
        n_total++; if (pc_last !== 11'd2047) $display("FAIL wrap_pc_top: got %0d want 2047", pc_last); else n_pass++;
        @(posedge clk); #3;
        n_total++;
        if ({o_rd_prog, o_pc, o_cycle_count} !== {1'b1, 11'd0, 32'd6144})
            $display("FAIL wrap_pc_zero: got prog %b pc %0d cnt %0d want 1 0 6144", o_rd_prog, o_pc, o_cycle_count);
        else n_pass++;
    endtask

    task automatic test_reset_during_sto();
        clear_prog();
        prog[0] = {LDI, 11'd1}; prog[1] = {STO, 11'd9}; prog[2] = {HLT, 11'd0};
        start_run();
        repeat (6) begin @(posedge clk); #3; end
        n_total++;
        if ({o_wr_ram, o_ram_addr, o_pc} !== {1'b1, 11'd9, 11'd1})
            $display("FAIL rst_sto_pre: got wr %b addr %0d pc %0d want 1 9 1", o_wr_ram, o_ram_addr, o_pc);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++;
        if ({o_wr_ram, o_rd_prog, o_halt, o_pc} !== {3'b000, 11'd0})
            $display("FAIL rst_sto_abort: got wr %b prog %b halt %b pc %0d want 0 0 0 0", o_wr_ram, o_rd_prog, o_halt, o_pc);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b0; en = 1'b1; #2;
        @(posedge clk); #3;
        n_total++;
        if ({o_rd_prog, o_pc} !== {1'b1, 11'd0})
            $display("FAIL rst_sto_refetch: got prog %b pc %0d want 1 0", o_rd_prog, o_pc);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            ph_t         q[$];
            ph_t         h;
            int          len, mcount, halt_n, cyc;
            logic [10:0] pc, halt_pc;
            logic [15:0] prev_ir, instr, halt_ir;
            logic [4:0]  op;
            logic [77:0] expv, actv;
            logic        e_acc, e_selb;
            logic [1:0]  e_sela;
            clear_prog();
            len = $urandom_range(3, 10);
            for (int i = 0; i < len - 1; i++) prog[i] = {5'($urandom_range(0, 31)), 11'($urandom)};
            prog[len-1] = {HLT, 11'($urandom)};
            q.push_back('{K_IDLE, 11'd0, 16'd0});
            pc = '0; prev_ir = '0; halt_pc = '0; halt_ir = '0;
            for (int n = 0; n < len; n++) begin
                instr = prog[pc];
                q.push_back('{K_FETCH, pc, prev_ir});
                q.push_back('{K_DEC, pc, prev_ir});
                if (instr[15:11] inside {LD, ADD, SUB}) q.push_back('{K_MEM, pc, instr});
                q.push_back('{K_EXEC, pc, instr});
                prev_ir = instr;
                pc = pc + 11'd1;
                if (instr[15:11] == HLT) begin halt_pc = pc; halt_ir = instr; break; end
            end
            rst = 1'b1; en = 1'b0;
            @(posedge clk); #1 rst = 1'b0;
            mcount = 0; halt_n = 0; cyc = 0;
            while (halt_n < 3 && cyc < 400) begin
                en = ($urandom_range(0, 3) != 0);
                #2;
                if (q.size() > 0) h = q[0];
                else h = '{K_HALT, halt_pc, halt_ir};
                op = h.ir[15:11];
                e_acc  = en && h.kind == K_EXEC && op >= LD && op <= SUBI;
                e_selb = h.kind == K_EXEC && (op == ADDI || op == SUBI);
                e_sela = (h.kind != K_EXEC) ? 2'b00 : (op == LDI) ? 2'b01 :
                         (op >= ADD && op <= SUBI) ? 2'b10 : 2'b00;
                expv = {h.pc, en && h.kind == K_FETCH, e_sela, e_selb, e_acc, op, h.ir[10:0], h.ir[10:0],
                        en && h.kind == K_MEM, en && h.kind == K_EXEC && op == STO, h.kind == K_HALT, 32'(mcount)};
                actv = {o_pc, o_rd_prog, o_selA, o_selB, o_wrAcc, o_op, o_operando, o_ram_addr,
                        o_rd_ram, o_wr_ram, o_halt, o_cycle_count};
                n_total++;
                if (actv !== expv)
                    $display("FAIL random_p%0d_c%0d: got %h want %h (en %b kind %0d)", p, cyc, actv, expv, en, h.kind);
                else n_pass++;
                if (h.kind == K_HALT) halt_n++;
                if (en && q.size() > 0) begin
                    if (q[0].kind != K_IDLE) mcount++;
                    void'(q.pop_front());
                end
                cyc++;
                @(posedge clk); #1;
            end
            n_total++;
            if (halt_n < 3) $display("FAIL random_p%0d_timeout: got %0d halt cycles want 3", p, halt_n);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        clear_prog();
        test_reset();
        test_basic_program();
        test_mem_ops();
        test_subi();
        test_pause_mem();
        test_reset_during_sto();
        test_random();
        test_pc_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
